// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final stage of the five-stage RISC-V pipeline. Accepts one retired
// instruction per cycle from the memory stage over a valid/ready handshake,
// formats load data (sign/zero extension), selects the writeback value, writes
// the 32x32 integer register file and serves decode's two read ports with a
// same-cycle write bypass. Also keeps a 64-bit retired-instruction counter.
//
// Ports
//   clk                  pipeline clock, rising-edge
//   rst_n                synchronous active-low reset
//   IR, RD, A, PC        instruction word, raw load data, ALU result, PC
//   v_in                 upstream entry valid
//   stall                hazard stall, blocks acceptance (one edge of lag)
//   r_out                registered ready to upstream
//   rs1_addr, rs2_addr   decode read addresses
//   rs1_data, rs2_data   combinational read data (x0 = 0, bypassed)
//   wb_en                register write occurring this cycle
//   wb_addr, wb_data     destination register and value being written
//   retired              retired-instruction count (wraps at 2^64)
// -----------------------------------------------------------------------------
module writeback_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IR,
   input  logic [31:0] RD,
   input  logic [31:0] A,
   input  logic [31:0] PC,
   input  logic        v_in,
   input  logic        stall,
   output logic        r_out,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [63:0] retired
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Load formatting: returns {writes, value}. Reserved funct3 (3/6/7)
   // produce no write.
   function automatic logic [32:0] f_load_fmt(input logic [2:0]  f3,
                                              input logic [31:0] d);
      logic [32:0] res;
      case (f3)
         3'd0:    res = {1'b1, {24{d[7]}},  d[7:0]};
         3'd1:    res = {1'b1, {16{d[15]}}, d[15:0]};
         3'd2:    res = {1'b1, d};
         3'd4:    res = {1'b1, 24'd0, d[7:0]};
         3'd5:    res = {1'b1, 16'd0, d[15:0]};
         default: res = {1'b0, d};
      endcase
      return res;
   endfunction

   logic        r_rdy;
   logic        r_vld_p0;
   logic [63:0] r_ret;
   logic [6:0]  r_opc_p0;
   logic [2:0]  r_f3_p0;
   logic [4:0]  r_dst_p0;
   logic [31:0] r_ld_p0;
   logic [31:0] r_alu_p0;
   logic [31:0] r_pc_p0;
   logic [31:0] r_regs [0:31];

   logic        w_accept;
   logic        w_writes;
   logic [31:0] w_val;
   logic [32:0] w_ld;
   logic        w_unused;

   // Only opcode, rd and funct3 of the instruction word matter here.
   assign w_unused = ^{IR[31:15]};

   assign w_accept = v_in & r_rdy;

   // ---- stage 0: accept from memory stage ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdy    <= 1'b0;
         r_vld_p0 <= 1'b0;
         r_ret    <= 64'd0;
      end else begin
         r_rdy    <= ~stall;
         r_vld_p0 <= w_accept;
         if (r_vld_p0)
            r_ret <= r_ret + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_opc_p0 <= IR[6:0];
         r_f3_p0  <= IR[14:12];
         r_dst_p0 <= IR[11:7];
         r_ld_p0  <= RD;
         r_alu_p0 <= A;
         r_pc_p0  <= PC;
      end
   end

   // ---- stage 0 -> register file: value select ----
   always_comb begin
      w_ld     = f_load_fmt(r_f3_p0, r_ld_p0);
      w_writes = 1'b0;
      w_val    = r_alu_p0;
      case (r_opc_p0)
         OPC_LOAD: begin
            w_writes = w_ld[32];
            w_val    = w_ld[31:0];
         end
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            w_writes = 1'b1;
            w_val    = r_alu_p0;
         end
         OPC_JAL, OPC_JALR: begin
            w_writes = 1'b1;
            w_val    = r_pc_p0 + 32'd4;
         end
         default: begin
            w_writes = 1'b0;
            w_val    = r_alu_p0;
         end
      endcase
   end

   assign wb_en   = r_vld_p0 & w_writes & (r_dst_p0 != 5'd0);
   assign wb_addr = r_dst_p0;
   assign wb_data = w_val;
   assign r_out   = r_rdy;
   assign retired = r_ret;

   // A reset edge discards the pending entry, including its write.
   always_ff @(posedge clk) begin
      if (rst_n && wb_en)
         r_regs[wb_addr] <= wb_data;
   end

   always_comb begin
      if (rs1_addr == 5'd0)
         rs1_data = 32'd0;
      else if (wb_en && (wb_addr == rs1_addr))
         rs1_data = wb_data;
      else
         rs1_data = r_regs[rs1_addr];
   end

   always_comb begin
      if (rs2_addr == 5'd0)
         rs2_data = 32'd0;
      else if (wb_en && (wb_addr == rs2_addr))
         rs2_data = wb_data;
      else
         rs2_data = r_regs[rs2_addr];
   end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] ir, rdat, alu, pc;
   logic        v_in, stall;
   logic        r_out;
   logic [4:0]  rs1a, rs2a;
   logic [31:0] rs1d, rs2d;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [63:0] retired;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];

   writeback_stage dut (
      .clk(clk), .rst_n(rst_n), .IR(ir), .RD(rdat), .A(alu), .PC(pc),
      .v_in(v_in), .stall(stall), .r_out(r_out),
      .rs1_addr(rs1a), .rs2_addr(rs2a), .rs1_data(rs1d), .rs2_data(rs2d),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [4:0] rd);
      return {17'h0, f3, rd, opc};
   endfunction

   // Reference model of the writeback decision.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] d,
                                  input logic [31:0] a, input logic [31:0] p);
      exp_t e;
      logic w;
      w = 1'b0;
      e.data = 32'h0;
      if (i[6:0] == 7'h03) begin
         w = 1'b1;
         if (i[14:12] == 3'd0)      e.data = $signed(d[7:0]);
         else if (i[14:12] == 3'd1) e.data = $signed(d[15:0]);
         else if (i[14:12] == 3'd2) e.data = d;
         else if (i[14:12] == 3'd4) e.data = {24'h0, d[7:0]};
         else if (i[14:12] == 3'd5) e.data = {16'h0, d[15:0]};
         else w = 1'b0;
      end else if (i[6:0] inside {7'h33, 7'h13, 7'h37, 7'h17}) begin
         w = 1'b1;
         e.data = a;
      end else if (i[6:0] inside {7'h6F, 7'h67}) begin
         w = 1'b1;
         e.data = p + 32'd4;
      end
      e.addr = i[11:7];
      e.en   = w && (i[11:7] != 5'd0);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [31:0] d,
                       input logic [31:0] a, input logic [31:0] p);
      ir = i; rdat = d; alu = a; pc = p;
      v_in = 1'b1;
      q.push_back(model(i, d, a, p));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++;
      if (r_out !== 1'b0) begin bad++; $display("FAIL reset_rout got %b want 0", r_out); end
      total++;
      if (wb_en !== 1'b0) begin bad++; $display("FAIL reset_wben got %b want 0", wb_en); end
      total++;
      if (retired !== 64'd0) begin bad++; $display("FAIL reset_retired got %0d want 0", retired); end
      rst_n = 1'b1;
      step();
      total++;
      if (r_out !== 1'b1) begin bad++; $display("FAIL reset_release_rout got %b want 1", r_out); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd3};
      logic [31:0] rds  [7] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h00008001,
                               32'hDEADBEEF, 32'hABCD127F, 32'h12345678};
      logic [31:0] want [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001,
                               32'hDEADBEEF, 32'h0000007F, 32'h0};
      exp_t e;
      for (int k = 0; k < 7; k++) begin
         rs1a = 5'd5;
         send(mk(7'h03, f3s[k], 5'd5), rds[k], 32'h0, 32'h200);
         step();
         v_in = 1'b0;
         e = q.pop_front();
         total++;
         if (wb_en !== e.en) begin
            bad++; $display("FAIL load%0d_wben got %b want %b", k, wb_en, e.en);
         end
         if (e.en) begin
            total++;
            if (wb_data !== e.data || wb_addr !== e.addr) begin
               bad++; $display("FAIL load%0d_wbdata got %h@%0d want %h@%0d", k, wb_data, wb_addr, e.data, e.addr);
            end
         end
         step();
         if (k != 6) begin
            total++;
            if (rs1d !== want[k]) begin
               bad++; $display("FAIL load%0d_reg got %h want %h", k, rs1d, want[k]);
            end
         end
      end
   endtask

   task automatic test_jal();
      exp_t e;
      rs1a = 5'd1;
      send(mk(7'h6F, 3'd0, 5'd1), 32'h0, 32'h0, 32'h00000100);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== 1'b1 || wb_data !== e.data || wb_data !== 32'h00000104) begin
         bad++; $display("FAIL jal_wb got en=%b %h want 1 %h", wb_en, wb_data, e.data);
      end
      step();
      total++;
      if (rs1d !== 32'h00000104) begin bad++; $display("FAIL jal_reg got %h want 00000104", rs1d); end
      send(mk(7'h67, 3'd0, 5'd1), 32'h0, 32'h0, 32'hFFFFFFFC);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== 1'b1 || wb_data !== e.data || wb_data !== 32'h0) begin
         bad++; $display("FAIL jalr_wrap got en=%b %h want 1 00000000", wb_en, wb_data);
      end
      step();
      total++;
      if (rs1d !== 32'h0) begin bad++; $display("FAIL jalr_reg got %h want 00000000", rs1d); end
   endtask

   task automatic test_nowrite();
      exp_t e;
      logic [63:0] r0;
      r0 = retired;
      rs1a = 5'd0;
      send(mk(7'h13, 3'd0, 5'd0), 32'h0, 32'h1234, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== e.en || wb_en !== 1'b0) begin bad++; $display("FAIL x0_wben got %b want 0", wb_en); end
      total++;
      if (rs1d !== 32'h0) begin bad++; $display("FAIL x0_read got %h want 0", rs1d); end
      step();
      total++;
      if (retired !== r0 + 64'd1) begin bad++; $display("FAIL x0_retired got %0d want %0d", retired, r0 + 64'd1); end
      send(mk(7'h23, 3'd2, 5'd4), 32'hzzzzzzzz, 32'h40, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== e.en || wb_en !== 1'b0) begin bad++; $display("FAIL store_wben got %b want 0", wb_en); end
      step();
      total++;
      if (retired !== r0 + 64'd2) begin bad++; $display("FAIL store_retired got %0d want %0d", retired, r0 + 64'd2); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [63:0] r0;
      r0 = retired;
      rs1a = 5'd3;
      rs2a = 5'd3;
      send(mk(7'h33, 3'd0, 5'd3), 32'h0, 32'd7, 32'h0);
      step();
      e = q.pop_front();
      total++;
      if (rs1d !== 32'd7 || rs1d !== e.data) begin bad++; $display("FAIL b2b_bypass1 got %h want 00000007", rs1d); end
      total++;
      if (rs2d !== 32'd7) begin bad++; $display("FAIL b2b_bypass1_rs2 got %h want 00000007", rs2d); end
      send(mk(7'h33, 3'd0, 5'd3), 32'h0, 32'd9, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (rs1d !== 32'd9 || wb_en !== e.en) begin bad++; $display("FAIL b2b_bypass2 got %h want 00000009", rs1d); end
      total++;
      if (retired !== r0 + 64'd1) begin bad++; $display("FAIL b2b_retired1 got %0d want %0d", retired, r0 + 64'd1); end
      step();
      total++;
      if (rs1d !== 32'd9) begin bad++; $display("FAIL b2b_reg got %h want 00000009", rs1d); end
      total++;
      if (retired !== r0 + 64'd2) begin bad++; $display("FAIL b2b_retired2 got %0d want %0d", retired, r0 + 64'd2); end
   endtask

   task automatic test_stall();
      exp_t e;
      logic [63:0] r0;
      r0 = retired;
      rs1a = 5'd9;
      // Stall rises in the same cycle as an accept; that entry still lands.
      stall = 1'b1;
      send(mk(7'h33, 3'd0, 5'd9), 32'h0, 32'h55, 32'h0);
      step();
      e = q.pop_front();
      total++;
      if (r_out !== 1'b0) begin bad++; $display("FAIL stall_rout0 got %b want 0", r_out); end
      total++;
      if (wb_en !== 1'b1 || wb_data !== e.data) begin bad++; $display("FAIL stall_latched got en=%b %h want 1 %h", wb_en, wb_data, e.data); end
      ir = mk(7'h33, 3'd0, 5'd10);
      alu = 32'h66;
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (r_out !== 1'b0 || wb_en !== 1'b0) begin
            bad++; $display("FAIL stall_hold%0d got rout=%b wben=%b want 0 0", k, r_out, wb_en);
         end
      end
      total++;
      if (rs1d !== 32'h55) begin bad++; $display("FAIL stall_write got %h want 00000055", rs1d); end
      stall = 1'b0;
      step();
      total++;
      if (r_out !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL stall_release got rout=%b wben=%b want 1 0", r_out, wb_en); end
      total++;
      if (retired !== r0 + 64'd1) begin bad++; $display("FAIL stall_retired got %0d want %0d", retired, r0 + 64'd1); end
      rs1a = 5'd10;
      send(mk(7'h33, 3'd0, 5'd10), 32'h0, 32'h66, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== 1'b1 || wb_data !== e.data || wb_addr !== e.addr) begin
         bad++; $display("FAIL stall_resume got en=%b %h want 1 %h", wb_en, wb_data, e.data);
      end
      step();
      total++;
      if (retired !== r0 + 64'd2) begin bad++; $display("FAIL stall_retired2 got %0d want %0d", retired, r0 + 64'd2); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      rs1a = 5'd7;
      send(mk(7'h13, 3'd0, 5'd7), 32'h0, 32'h77, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      step();
      send(mk(7'h03, 3'd2, 5'd7), 32'hDEADBEEF, 32'h0, 32'h0);
      step();
      v_in = 1'b0;
      e = q.pop_front();
      total++;
      if (wb_en !== 1'b1 || wb_data !== e.data) begin bad++; $display("FAIL rstmid_pending got en=%b %h want 1 %h", wb_en, wb_data, e.data); end
      rst_n = 1'b0;
      step();
      total++;
      if (rs1d !== 32'h77) begin bad++; $display("FAIL rstmid_x7 got %h want 00000077", rs1d); end
      total++;
      if (retired !== 64'd0) begin bad++; $display("FAIL rstmid_retired got %0d want 0", retired); end
      total++;
      if (r_out !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got rout=%b wben=%b want 0 0", r_out, wb_en); end
      rst_n = 1'b1;
      step();
      total++;
      if (r_out !== 1'b1) begin bad++; $display("FAIL rstmid_release got %b want 1", r_out); end
      total++;
      if (retired !== 64'd0) begin bad++; $display("FAIL rstmid_retired_hold got %0d want 0", retired); end
   endtask

   initial begin
      rst_n = 1'b0;
      v_in  = 1'b0;
      stall = 1'b0;
      ir = 32'h0; rdat = 32'h0; alu = 32'h0; pc = 32'h0;
      rs1a = 5'd0; rs2a = 5'd0;
      test_reset();
      test_loads();
      test_jal();
      test_nowrite();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d want 0", q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage RISC-V pipeline. It accepts retired instructions from the memory stage over the valid/ready handshake and formats load data with sign or zero extension. It selects the writeback value, writes the 32x32 integer register file and exposes that file's two read ports to decode, with same-cycle write bypass. It also counts retired instructions.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- IR  in  32  instruction word from memory stage
- RD  in  32  raw load data from memory stage (LB/LH data in low bits, upper bits don't-care; Z for stores)
- A  in  32  ALU result / effective address
- PC  in  32  instruction PC
- v_in  in  1  upstream entry valid
- stall  in  1  hazard stall, blocks acceptance
- r_out  out  1  ready to upstream (registered)
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_data, rs2_data  out  32 each  combinational read data
- wb_en  out  1  register write occurring this cycle (forwarding)
- wb_addr  out  5  destination register
- wb_data  out  32  value being written
- retired  out  64  retired-instruction count

## Operation
- Accept: rising edge with v_in & r_out latches IR, RD, A and PC into the stage register and sets wb_valid=1. With no accept, wb_valid<=0 and the latched fields hold.
- r_out <= ~stall every non-reset edge.
- Writeback value is decoded combinationally from the latched IR[6:0], funct3 = IR[14:12]:
  - 0000011 load: funct3 0 gives sext(RD[7:0]); 1 gives sext(RD[15:0]); 2 gives RD; 4 gives zext(RD[7:0]); 5 gives zext(RD[15:0]); 3/6/7 give no write.
  - 0110011, 0010011, 0110111, 0010111 (OP, OP-IMM, LUI, AUIPC) give A.
  - 1101111, 1100111 (JAL, JALR) give PC+4, mod 2^32.
  - 0100011, 1100011 and all other opcodes give no write.
- wb_en = wb_valid & writes & (IR[11:7] != 0). wb_addr = IR[11:7]. wb_data = selected value.
- Register write: regs[wb_addr] <= wb_data on the edge ending a cycle with wb_en=1. x0 is never written.
- Retire: retired += 1 on every edge ending a cycle with wb_valid=1, including no-write instructions. Wraps at 2^64.
- Read ports, per port:
  - address 0 gives 0;
  - else if wb_en and wb_addr matches, gives wb_data (bypass);
  - else gives regs[addr].
- Stall does not cancel an entry already latched: its write and retire complete.

## Timing
- Reset (rst_n=0 at an edge): r_out=0, wb_valid=0 (so wb_en=0), retired=0.
  - Register contents x1–x31 are not reset.
  - wb_addr and wb_data are don't-care while wb_en=0.
- First edge after reset release sets r_out=1 if stall=0, so the earliest accept is the second edge after release.
- Latency: accept at edge N; wb_en/wb_data are visible during cycle N..N+1; register write and retired increment land at edge N+1.
- Throughput: one instruction per cycle while stall=0.
- Stall asserted in cycle k gives r_out=0 from edge k+1. An accept at edge k+1 is still possible if r_out was 1 during cycle k.
- Reset mid-operation: a pending latched entry is discarded, with no write and no retire increment.
- Simultaneous write and read of the same register: the read returns the new value via bypass. Write to x0 with read of x0 returns 0.

## Test plan
- LB with RD=0x000000F0, then LBU with the same RD -> x5 = 0xFFFFFFF0, then x5 = 0x000000F0. LH with RD=0x00008001 -> 0xFFFF8001.
- JAL rd=x1, PC=0x00000100 -> wb_data = 0x00000104, x1 reads 0x00000104 from the next cycle. Then PC=0xFFFFFFFC -> 0x00000000.
- ADDI rd=x0, A=0x1234 -> wb_en=0, rs1_addr=0 reads 0, retired increments by 1. A store -> no write, retired increments.
- Back-to-back accepts: ADD x3 (A=7) then SUB x3 (A=9), with rs1_addr=3 held -> rs1_data reads 7 in the cycle of the first write, then 9 in the next cycle (bypass). Retired increments 2 over 2 cycles.
- Stall held 3 cycles with v_in=1 -> r_out low for exactly those cycles+1 edge of lag, no accepts while r_out=0. Entry latched before the stall still writes.
- Reset asserted with wb_valid=1 (LW x7, RD=0xDEADBEEF) -> x7 unchanged, retired=0, r_out=0. After release, r_out rises on the first edge.
